// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the N-master Wishbone request side and the shared slave side.
// Latency: none, wires only.
// Backpressure: none here; the slave's ack is the only flow control on the bus.
//
// Ports:
//   m_*_i / m_*_o : per-master signals, master k at bit k or slice [k*W +: W].
//   s_*_o / s_*_i : the single shared slave.
//   grant_o       : one-hot registered grant, for status/debug.
// Modports:
//   master : the arbiter's view. It masters the shared slave bus.
//   slave  : the environment's view, the mirror image of master.
interface wb_rr_arbiter_if #(
  parameter int NUM_M = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int SW = DW / 8;

  logic [NUM_M-1:0]    m_cyc_i;
  logic [NUM_M-1:0]    m_stb_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M*SW-1:0] m_sel_i;
  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M-1:0]    m_ack_o;
  logic [NUM_M-1:0]    m_err_o;
  logic [DW-1:0]       m_dat_o;

  logic                s_cyc_o;
  logic                s_stb_o;
  logic                s_we_o;
  logic [SW-1:0]       s_sel_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic                s_ack_i;
  logic [DW-1:0]       s_dat_i;

  logic [NUM_M-1:0]    grant_o;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i,
    output grant_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave, with the grant held per cyc burst.
// Latency: 1 IDLE cycle to grant, 1 IDLE cycle between owners; ack and read data are combinational.
// Backpressure: losing masters wait with cyc high. The slave's ack paces the owner with no buffering.
//
// Ports:
//   clk, rst : clock; asynchronous active-high reset.
//   bus      : wb_rr_arbiter_if.master, carrying the per-master requests, the shared slave and grant_o.
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the bus watchdog. Without it, m_err_o is 0
//   and a hung slave keeps the grant.
module wb_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  wb_rr_arbiter_if.master bus
);
  localparam int SW = DW / 8;
  localparam int PW = $clog2(NUM_M);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  if (NUM_M < 2 || NUM_M > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("wb_rr_arbiter: NUM_M must be 2..8 and TIMEOUT 1..65535");
  end

  logic [0:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [NUM_M-1:0] grant_q;
  logic             own;
  logic             timeout;

  logic [PW-1:0]    cand;
  logic [PW-1:0]    win_idx;
  logic             win_found;
  logic [PW-1:0]    ptr_next;

  logic             sel_cyc, sel_stb, sel_we;
  logic [SW-1:0]    sel_sel;
  logic [AW-1:0]    sel_adr;
  logic [DW-1:0]    sel_dat;

  assign own = (state == ST_OWN);

  // Search upward from ptr with wrap. The first requester found wins, so the
  // master released last (ptr = its index + 1) has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < NUM_M; i++) begin
      if (!win_found && bus.m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == PW'(NUM_M - 1)) ? '0 : cand + 1'b1;
    end
  end

  assign ptr_next = (gnt_idx == PW'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;

  // Forward mux of the granted master's request.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_sel = '0;
    sel_adr = '0;
    sel_dat = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_cyc = bus.m_cyc_i[k];
        sel_stb = bus.m_stb_i[k];
        sel_we  = bus.m_we_i[k];
        sel_sel = bus.m_sel_i[k*SW +: SW];
        sel_adr = bus.m_adr_i[k*AW +: AW];
        sel_dat = bus.m_dat_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      grant_q <= '0;
    end else if (state == ST_IDLE) begin
      if (win_found) begin
        state   <= ST_OWN;
        gnt_idx <= win_idx;
        grant_q <= NUM_M'(1) << win_idx;
      end
    end else if (!sel_cyc || timeout) begin
      state   <= ST_IDLE;
      ptr     <= ptr_next;
      grant_q <= '0;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Counts only stalled strobe cycles. It restarts on every ack or stb gap,
  // so a long burst that keeps making progress never trips it.
  assign timeout = own && (wd_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (!own || timeout || !sel_stb || bus.s_ack_i) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // grant_q is zero in IDLE, so ack/err need no extra state gating. On a
  // timeout the slave request is withdrawn in that cycle and any stray ack is
  // dropped, because the master sees err instead.
  assign bus.s_cyc_o = own & sel_cyc & ~timeout;
  assign bus.s_stb_o = own & sel_stb & ~timeout;
  assign bus.s_we_o  = own & sel_we;
  assign bus.s_sel_o = own ? sel_sel : '0;
  assign bus.s_adr_o = own ? sel_adr : '0;
  assign bus.s_dat_o = own ? sel_dat : '0;
  assign bus.m_ack_o = grant_q & {NUM_M{bus.s_ack_i & ~timeout}};
  assign bus.m_err_o = grant_q & {NUM_M{timeout}};
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant_q;
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised N-master Wishbone arbiter in front of the single shared SDRAM Wishbone slave (`sdram_top`) in the user DMA subsystem. It generalises the fixed 4-master, fixed-priority, per-ack arbiter in several ways:
- master count and bus widths are parameters;
- arbitration is fair round-robin;
- grant is held for a whole `cyc` burst rather than a single ack;
- an optional bus-timeout watchdog returns `err` to a master whose slave never acks.

## Interface
- `NUM_M`, default 4: number of masters, 2..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width; `SW = DW/8` select bits.
- `TIMEOUT`, default 255: watchdog limit in cycles, 1..65535. Used only with the configuration macro defined.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `m_cyc_i` in NUM_M: per-master cycle; bit k is master k.
- `m_stb_i` in NUM_M: per-master strobe.
- `m_we_i` in NUM_M: per-master write enable.
- `m_sel_i` in NUM_M*SW: byte selects, master k at [k*SW +: SW].
- `m_adr_i` in NUM_M*AW: addresses, packed the same way.
- `m_dat_i` in NUM_M*DW: write data, packed the same way.
- `m_ack_o` out NUM_M: ack, routed to the granted master only.
- `m_err_o` out NUM_M: error/timeout, to the granted master only.
- `m_dat_o` out DW: read data, broadcast to all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave control.
- `s_sel_o` out SW, `s_adr_o` out AW, `s_dat_o` out DW: slave selects, address and write data.
- `s_ack_i` in 1: slave ack.
- `s_dat_i` in DW: slave read data.
- `grant_o` out NUM_M: one-hot registered grant, for status/debug.

## Operation
- **States:** IDLE and OWN.
- **IDLE:**
  - `grant_o` = 0.
  - All `s_*` outputs are driven 0.
  - `s_ack_i` is ignored and not routed.
- **IDLE → OWN:** when any `m_cyc_i` is high.
  - The winner is the first requesting index found searching upward from `ptr`, wrapping NUM_M-1 → 0.
  - `ptr` is a $clog2(NUM_M)-bit register, reset to 0.
- **In OWN with winner g:**
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`, `s_adr_o` and `s_dat_o` mux combinationally from master g.
  - `m_ack_o[g]` = `s_ack_i`; all other ack bits are 0.
  - `m_dat_o` = `s_dat_i` at all times.
- **Burst hold:** grant persists while `m_cyc_i[g]` stays high, across any number of acks and any number of `stb` deassertions.
- **OWN → IDLE:** when `m_cyc_i[g]` is low.
  - `ptr` is set to (g+1) mod NUM_M.
  - The released master has lowest priority next round.
- **Grant changes:** never change grant mid-burst. Requests from other masters only wait.
- **Simultaneous events:**
  - `m_cyc_i[g]` falling in the same cycle as `s_ack_i`: the ack is still routed to g that cycle.
  - Master g raising `cyc` again in the IDLE cycle right after release is arbitrated normally, at its now-lowest priority.
- **Reset:**
  - `rst` asserted at any time, including mid-burst, forces IDLE immediately.
  - `ptr` = 0, `grant_o` = 0, all `m_ack_o`/`m_err_o`/`s_*` = 0, watchdog count = 0.
  - An in-flight slave transaction is abandoned. Its late `s_ack_i` is ignored because the state is IDLE.

## Timing
- **Arbitration latency:** `m_cyc_i` high at edge n gives `grant_o` and `s_cyc_o` high after edge n+1. That is one cycle in IDLE minimum.
- **Release gap:** exactly one IDLE cycle between consecutive owners. Peak bus utilisation for back-to-back single transfers is therefore 50%.
- **Ack path:** combinational; `s_ack_i` → `m_ack_o[g]` has zero cycles of latency.
- **Slave data path:** combinational; `m_dat_o` = `s_dat_i` with zero cycles of latency.

## Configuration
- **`WB_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter runs in OWN. It increments each cycle in which `s_stb_o` is high and `s_ack_i` is low.
  - It clears on `s_ack_i`, on `stb` low, and in IDLE.
  - When the count reaches TIMEOUT, `m_err_o[g]` pulses for 1 cycle and the counter clears.
  - `s_cyc_o` and `s_stb_o` are forced 0 in that cycle.
  - The state goes to IDLE with `ptr` = g+1, even though `m_cyc_i[g]` is still high.
- **`WB_ARB_TIMEOUT_EN` undefined:**
  - No counter exists.
  - `m_err_o` is tied to 0.
  - A hung slave holds the grant indefinitely.

## Test plan
- **Reset values:** assert `rst` → `grant_o`=0, all `s_*`=0, `m_ack_o`=0. Release, no requests → remains IDLE 10 cycles.
- **Round-robin order:** NUM_M=4, all `m_cyc_i`=4'b1111, each master does 1 transfer then drops `cyc` → grant order 0,1,2,3,0, with one IDLE cycle between each.
- **Burst hold:** master 2 holds `cyc` for 8 acked reads at addresses 0x100..0x11C while master 0 requests → `grant_o` stays 4'b0100 for all 8 acks. Master 0 is granted 2 cycles after master 2 drops `cyc`.
- **Ack/release same cycle:** master 1 drops `cyc` in the cycle the slave acks with data 0xDEADBEEF → `m_ack_o`=4'b0010 and `m_dat_o`=0xDEADBEEF that cycle. Next cycle is IDLE.
- **Mid-burst reset:** assert `rst` in the 3rd beat of a master-3 write burst → `s_cyc_o`=0 asynchronously, `ptr`=0. After release with all masters requesting, master 0 is granted first.
- **Watchdog:** `WB_ARB_TIMEOUT_EN` defined, TIMEOUT=16, slave never acks master 0 → `m_err_o`=4'b0001 exactly once. `grant_o` is 4'b0001 for 17 cycles, then 0. Waiting master 1 is granted next.
